// File: rtl/sar_conv_model.sv
// ============================================================================
//  Module   : sar_conv_model
//  Purpose  : Behavioural SAR-ADC conversion engine. It samples a real
//             differential input and resolves an offset-binary code, one bit
//             per clock.
//  Options  : SAR_VCM_CHECK_EN enables the input common-mode check (cm_err).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sar_conv_model #(
    parameter int  N_BITS = 8,
    parameter real CM_TOL = 0.05
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  real               vinp,
    input  real               vinn,
    input  real               vcm,
    input  real               vrefp,
    input  real               vrefn,
    output logic              busy,
    output logic              valid,
    output logic [N_BITS-1:0] dout,
    output logic              ref_err,
    output logic              cm_err
);

    localparam int                 c_IDX_W   = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam logic [c_IDX_W-1:0] c_IDX_MAX = c_IDX_W'(N_BITS - 1);
    localparam real                c_CODES   = 2.0 ** N_BITS;

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_SAMPLE = 2'd1;
    localparam logic [1:0] c_S_CONV   = 2'd2;
    localparam logic [1:0] c_S_DONE   = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [N_BITS-1:0]  r_code;
    logic [c_IDX_W-1:0] r_idx;
    logic [N_BITS-1:0]  r_dout;
    logic               r_ref_err;
    real                r_vd;
    real                r_vneg;
    real                r_lsb;

    logic [N_BITS-1:0]  w_trial;
    logic [N_BITS-1:0]  w_code_next;
    logic               w_take;
    real                w_thr;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_IDLE:   if (start) w_state_next = c_S_SAMPLE;
            c_S_SAMPLE: w_state_next = c_S_CONV;
            c_S_CONV:   if (r_idx == '0) w_state_next = c_S_DONE;
            c_S_DONE:   w_state_next = start ? c_S_SAMPLE : c_S_IDLE;
            default:    w_state_next = c_S_IDLE;
        endcase
    end

    always_comb begin
        busy  = 1'b0;
        valid = 1'b0;
        case (r_state)
            c_S_SAMPLE: busy  = 1'b1;
            c_S_CONV:   busy  = 1'b1;
            c_S_DONE:   valid = 1'b1;
            default:    ;
        endcase
    end

    // Threshold for the bit under test, measured up from the bottom of the range.
    always_comb begin
        w_trial     = r_code | (N_BITS'(1) << r_idx);
        w_thr       = r_vneg + r_lsb * $itor({{(32-N_BITS){1'b0}}, w_trial});
        w_take      = (r_vd >= w_thr);
        w_code_next = w_take ? w_trial : r_code;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_code    <= '0;
            r_idx     <= '0;
            r_dout    <= '0;
            r_ref_err <= 1'b0;
            r_vd      <= 0.0;
            r_vneg    <= 0.0;
            r_lsb     <= 0.0;
        end else begin
            case (r_state)
                c_S_SAMPLE: begin
                    r_vd      <= vinp - vinn;
                    r_vneg    <= vrefn - vrefp;
                    r_lsb     <= 2.0 * (vrefp - vrefn) / c_CODES;
                    r_ref_err <= (vrefp <= vrefn);
                    r_code    <= '0;
                    r_idx     <= c_IDX_MAX;
                end
                c_S_CONV: begin
                    r_code <= w_code_next;
                    if (r_idx == '0) begin
                        r_dout <= r_ref_err ? '0 : w_code_next;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dout    = r_dout;
    assign ref_err = r_ref_err;

`ifdef SAR_VCM_CHECK_EN
    logic r_cm_err;
    real  w_cm_dev;

    always_comb begin
        w_cm_dev = (vinp + vinn) / 2.0 - vcm;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cm_err <= 1'b0;
        end else if (r_state == c_S_SAMPLE) begin
            r_cm_err <= (w_cm_dev > CM_TOL) || (w_cm_dev < -CM_TOL);
        end
    end

    assign cm_err = r_cm_err;
`else
    // vcm and CM_TOL are deliberately not used in this build.
    logic w_unused_vcm;
    assign w_unused_vcm = (vcm > CM_TOL);
    assign cm_err       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sar_conv_model.sv
// ============================================================================
//  Module   : tb_sar_conv_model
//  Purpose  : Directed self-checking bench for sar_conv_model (N_BITS=8).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sar_conv_model;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    real        vinp, vinn, vcm, vrefp, vrefn;
    logic       busy, valid, ref_err, cm_err;
    logic [7:0] dout;

    int checks   = 0;
    int failures = 0;

    sar_conv_model #(.N_BITS(8), .CM_TOL(0.05)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .vinp    (vinp),
        .vinn    (vinn),
        .vcm     (vcm),
        .vrefp   (vrefp),
        .vrefn   (vrefn),
        .busy    (busy),
        .valid   (valid),
        .dout    (dout),
        .ref_err (ref_err),
        .cm_err  (cm_err)
    );

    always #5 clock = ~clock;

    // Pulse start for one edge (E0), then return at the negedge where valid
    // is seen; lat is the number of edges after E0, or -1 on timeout.
    task automatic start_and_wait(output int lat);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clock);
            if (valid === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks += 5;
        if (busy !== 1'b0)    begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (valid !== 1'b0)   begin failures++; $display("FAIL reset_valid: got %b expected 0", valid); end
        if (dout !== 8'd0)    begin failures++; $display("FAIL reset_dout: got %0d expected 0", dout); end
        if (ref_err !== 1'b0) begin failures++; $display("FAIL reset_ref_err: got %b expected 0", ref_err); end
        if (cm_err !== 1'b0)  begin failures++; $display("FAIL reset_cm_err: got %b expected 0", cm_err); end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_latency;
        int lat;
        vinp = 0.5008; vinn = 0.5;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL lat_busy_sample: got %b expected 1", busy); end
        lat = -1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clock);
            if (valid === 1'b1) begin lat = n; break; end
        end
        checks += 2;
        if (lat !== 9)      begin failures++; $display("FAIL lat_cycles: got %0d expected 9", lat); end
        if (dout !== 8'd128) begin failures++; $display("FAIL lat_dout: got %0d expected 128", dout); end
        @(negedge clock);
        checks += 2;
        if (valid !== 1'b0)  begin failures++; $display("FAIL lat_valid_pulse: got %b expected 0", valid); end
        if (dout !== 8'd128) begin failures++; $display("FAIL lat_dout_hold: got %0d expected 128", dout); end
    endtask

    task automatic test_codes;
        real        vd_tab  [4] = '{0.1008, -0.0492, 0.25, -0.25};
        logic [7:0] exp_tab [4] = '{8'd192, 8'd96, 8'd255, 8'd0};
        int lat;
        for (int i = 0; i < 4; i++) begin
            vinn = 0.5; vinp = 0.5 + vd_tab[i];
            start_and_wait(lat);
            checks += 2;
            if (lat !== 9) begin failures++; $display("FAIL code_lat[%0d]: got %0d expected 9", i, lat); end
            if (dout !== exp_tab[i]) begin
                failures++; $display("FAIL code_dout[%0d]: got %0d expected %0d", i, dout, exp_tab[i]);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_back_to_back;
        int gap;
        vinn = 0.5; vinp = 0.6008;
        start = 1'b1;
        gap = -1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clock);
            if (valid === 1'b1) begin gap = n; break; end
        end
        checks++;
        if (gap < 0) begin failures++; $display("FAIL b2b_first: got timeout expected valid"); end
        for (int k = 0; k < 3; k++) begin
            gap = -1;
            for (int n = 1; n <= 30; n++) begin
                @(negedge clock);
                if (valid === 1'b1) begin gap = n; break; end
            end
            checks += 2;
            if (gap !== 10)     begin failures++; $display("FAIL b2b_period[%0d]: got %0d expected 10", k, gap); end
            if (dout !== 8'd192) begin failures++; $display("FAIL b2b_dout[%0d]: got %0d expected 192", k, dout); end
        end
        start = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_busy_ignore;
        int nvalid = 0;
        vinn = 0.5; vinp = 0.6008;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int n = 1; n <= 25; n++) begin
            start = (n == 3) || (n == 5);
            @(negedge clock);
            if (valid === 1'b1) nvalid++;
        end
        start = 1'b0;
        checks += 2;
        if (nvalid !== 1)   begin failures++; $display("FAIL busy_ignore_count: got %0d expected 1", nvalid); end
        if (dout !== 8'd192) begin failures++; $display("FAIL busy_ignore_dout: got %0d expected 192", dout); end
    endtask

    task automatic test_mid_reset;
        int nvalid = 0;
        int lat;
        vinn = 0.5; vinp = 0.5008;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks += 3;
        if (busy !== 1'b0)  begin failures++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        if (valid !== 1'b0) begin failures++; $display("FAIL midrst_valid: got %b expected 0", valid); end
        if (dout !== 8'd0)  begin failures++; $display("FAIL midrst_dout: got %0d expected 0", dout); end
        for (int n = 0; n < 12; n++) begin
            @(negedge clock);
            if (valid === 1'b1) nvalid++;
        end
        checks++;
        if (nvalid !== 0) begin failures++; $display("FAIL midrst_no_valid: got %0d expected 0", nvalid); end
        start_and_wait(lat);
        checks += 2;
        if (lat !== 9)       begin failures++; $display("FAIL midrst_lat: got %0d expected 9", lat); end
        if (dout !== 8'd128) begin failures++; $display("FAIL midrst_dout_after: got %0d expected 128", dout); end
        @(negedge clock);
    endtask

    task automatic test_ref_err;
        int lat;
        vinn = 0.5; vinp = 0.6008;
        vrefp = 0.4; vrefn = 0.6;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        checks++;
        if (ref_err !== 1'b1) begin failures++; $display("FAIL referr_flag: got %b expected 1", ref_err); end
        lat = -1;
        for (int n = 2; n <= 30; n++) begin
            @(negedge clock);
            if (valid === 1'b1) begin lat = n; break; end
        end
        checks += 2;
        if (lat !== 9)     begin failures++; $display("FAIL referr_lat: got %0d expected 9", lat); end
        if (dout !== 8'd0) begin failures++; $display("FAIL referr_dout: got %0d expected 0", dout); end
        @(negedge clock);
        vrefp = 0.6; vrefn = 0.4;
        start_and_wait(lat);
        checks += 2;
        if (ref_err !== 1'b0) begin failures++; $display("FAIL referr_clear: got %b expected 0", ref_err); end
        if (dout !== 8'd192)  begin failures++; $display("FAIL referr_dout_after: got %0d expected 192", dout); end
        @(negedge clock);
    endtask

    task automatic test_cm;
        int   lat;
        logic exp_cm_a;
`ifdef SAR_VCM_CHECK_EN
        exp_cm_a = 1'b1;
`else
        exp_cm_a = 1'b0;
`endif
        vrefp = 0.55; vrefn = 0.45; vcm = 0.5;
        vinp = 0.60; vinn = 0.58;
        start_and_wait(lat);
        checks += 2;
        if (cm_err !== exp_cm_a) begin failures++; $display("FAIL cm_high_flag: got %b expected %b", cm_err, exp_cm_a); end
        if (dout !== 8'd153)     begin failures++; $display("FAIL cm_high_dout: got %0d expected 153", dout); end
        @(negedge clock);
        vinp = 0.51; vinn = 0.49;
        start_and_wait(lat);
        checks += 2;
        if (cm_err !== 1'b0)  begin failures++; $display("FAIL cm_ok_flag: got %b expected 0", cm_err); end
        if (dout !== 8'd153)  begin failures++; $display("FAIL cm_ok_dout: got %0d expected 153", dout); end
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0;
        vinp = 0.5; vinn = 0.5; vcm = 0.5; vrefp = 0.6; vrefn = 0.4;
        @(negedge clock);
        test_reset();
        test_latency();
        test_codes();
        test_back_to_back();
        test_busy_ignore();
        test_mid_reset();
        test_ref_err();
        test_cm();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sar_conv_model.md
Name: sar_conv_model

Overview:
- Behavioural SAR-ADC conversion engine for the SAR-ADC modeling flow.
- It is the consumer of the ideal reference voltages (vcm, vrefp, vrefn) that the reference model produces.
- On a start request it samples a differential real-valued input and resolves an N-bit offset-binary code by successive approximation against those references, one bit per clock.
- Sits between the analog front-end/reference models and the digital back-end.

Parameters:
- N_BITS, 8, conversion resolution in bits (range 2..16)
- CM_TOL, 0.05, allowed |input common mode − vcm| in V; used only with the optional feature

Ports:
- clock  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- start  input  1  conversion request, level-sampled
- vinp  input  real  positive input voltage
- vinn  input  real  negative input voltage
- vcm  input  real  common-mode reference
- vrefp  input  real  positive reference
- vrefn  input  real  negative reference
- busy  output  1  high in SAMPLE and CONV
- valid  output  1  one-cycle pulse, dout is a new result
- dout  output  N_BITS  offset-binary result, held until the next result
- ref_err  output  1  reference fault seen at last sample
- cm_err  output  1  common-mode fault (optional feature)

Behaviour:
- Reset (synchronous, takes priority, may occur at any point including mid-conversion):
  - state=IDLE; busy=0, valid=0, dout=0, ref_err=0, cm_err=0.
  - Internal trial code and bit index cleared.
- FSM states: IDLE, SAMPLE, CONV, DONE.
- IDLE: start=1 → SAMPLE.
- SAMPLE (1 cycle):
  - Latch vd=vinp−vinn, vfs=vrefp−vrefn, vneg=−vfs.
  - lsb = 2·vfs / 2^N_BITS.
  - ref_err <= (vrefp <= vrefn).
  - code=0, idx=N_BITS−1.
  - → CONV.
- CONV (N_BITS cycles), per edge:
  - trial = code | (1<<idx).
  - thr = vneg + trial·lsb.
  - If vd >= thr then code <= trial.
  - If idx==0 → DONE, else idx <= idx−1.
- DONE (1 cycle):
  - valid=1; dout = ref_err ? 0 : code.
  - start=1 → SAMPLE (back-to-back), else → IDLE.
- Latency: start sampled at edge E0 → valid high after edge E0+N_BITS+1. Minimum period N_BITS+2 cycles.
- start is ignored while busy=1 (SAMPLE or CONV); there is no queueing.
- Inputs are sampled only in SAMPLE. Changes to vinp/vinn/refs during CONV have no effect.
- Transfer function:
  - code = floor((vd+vfs)/lsb), saturated to [0, 2^N_BITS−1].
  - vd >= +vfs → all ones; vd < −vfs → 0.
- valid is deasserted in every state except DONE. dout changes only on entry to DONE.
- ref_err and cm_err update only in SAMPLE and persist until the next SAMPLE or reset.
- Reset asserted during CONV: no valid pulse is produced for the aborted conversion; dout reads 0.

Optional Feature:
- Macro: SAR_VCM_CHECK_EN.
- Defined:
  - In SAMPLE, cm_err <= (abs((vinp+vinn)/2 − vcm) > CM_TOL).
  - The conversion still completes normally; cm_err is a flag only.
- Undefined:
  - cm_err tied to 0, vcm input unused.
  - Port list is unchanged in both builds.

Test Plan:
- N_BITS=8, vrefp=0.6, vrefn=0.4, vinp−vinn=+0.0008, start pulse at E0 → busy high from E1, valid single pulse after E9, dout=128.
- Same refs, vd=+0.1008 → dout=192. vd=−0.0492 → dout=96. vd=+0.25 → dout=255. vd=−0.25 → dout=0.
- start held high continuously, vd=+0.1008 → valid every 10 cycles, dout=192 each time. Extra start pulses during busy produce no extra valid.
- Reset asserted at the 4th CONV cycle → next cycle busy=0, valid=0, dout=0, state IDLE. A new start then converts correctly.
- vrefp=0.4, vrefn=0.6, any vd → ref_err=1 from the cycle after SAMPLE, valid pulse with dout=0. Restoring refs and converting again → ref_err=0.
- With SAR_VCM_CHECK_EN, vcm=0.5: vinp=0.60, vinn=0.58 → cm_err=1, dout=153. vinp=0.51, vinn=0.49 → cm_err=0. Without the macro → cm_err=0 in both cases.
